diff_clk_monitor: RTL
=====================

DIFF_CLK_MONITOR -- requirements
Module: diff_clk_monitor

Interface
REQ-001 Parameter NCH, default 4, number of differential input channels (1..8).
REQ-002 Parameter CNT_W, default 24, width of each per-channel edge count.
REQ-003 Parameter GATE_CYCLES, default 1000000, measurement window length in clk cycles (>=2).
REQ-004 Parameter LOS_CYCLES, default 1024, edge-free clk cycles that declare loss of signal (>=1).
REQ-005 Parameter HOLDOFF_CYCLES, default 256, clk cycles a newly chosen channel must stay healthy before it is qualified (>=1).
REQ-006 Parameter DIFF_TERM, default "FALSE", differential termination applied to every input buffer.
REQ-007 clk  input  1  system clock; all logic is synchronous to its rising edge; one clock domain.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 in_p  input  NCH  differential positive legs, connected directly to top-level pins.
REQ-010 in_n  input  NCH  differential negative legs, connected directly to top-level pins.
REQ-011 sig_o  output  NCH  raw buffered single-ended signals, combinational from the buffers.
REQ-012 edge_cnt  output  NCH*CNT_W  per-channel rising-edge counts of the last closed window, channel k at bits [k*CNT_W +: CNT_W].
REQ-013 cnt_valid  output  1  one-cycle pulse when edge_cnt updates.
REQ-014 los  output  NCH  per-channel loss-of-signal flags.
REQ-015 sel  output  3  index of selected channel.
REQ-016 sel_valid  output  1  selected channel qualified.
REQ-017 sel_change  output  1  one-cycle pulse when sel_valid rises.
REQ-018 sel_sig  output  1  registered synchronised level of selected channel.

Function
REQ-019 Each channel SHALL use one differential input buffer (low-power mode, DIFF_TERM as parameterised) feeding sig_o[k].
REQ-020 Each buffered signal SHALL pass through a 2-flop synchroniser plus one edge register; a rising edge pulse asserts 3 clk cycles after the pin transition is first sampled.
REQ-021 Inputs SHALL be below clk/2; faster inputs are outside the contract.
REQ-022 A gate counter SHALL count 0..GATE_CYCLES-1 and wrap; on the terminal cycle every accumulator SHALL be latched into edge_cnt, cleared, and cnt_valid SHALL pulse for one cycle.
REQ-023 An edge pulse on the terminal cycle SHALL be counted in the closing window.
REQ-024 Accumulators SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 Per-channel silence counter SHALL clear on each edge pulse, else increment, saturating at LOS_CYCLES; los[k]=1 iff counter==LOS_CYCLES.
REQ-026 Selection FSM states: SEARCH, HOLDOFF, LOCKED.
REQ-027 SEARCH: sel_valid=0; when any los[k]=0, load sel with lowest such k, clear hold counter, go HOLDOFF next cycle.
REQ-028 HOLDOFF: sel_valid=0; if los[sel]=1 go SEARCH; else after HOLDOFF_CYCLES cycles go LOCKED.
REQ-029 LOCKED: sel_valid=1; if los[sel]=1 go SEARCH, sel_valid drops same cycle as the state change; non-revertive (a healthier lower index does not cause a switch).
REQ-030 sel_change SHALL pulse on the cycle sel_valid goes 0->1.
REQ-031 sel_sig SHALL equal the synchronised level of channel sel when sel_valid=1, else 0, registered.
REQ-032 sel SHALL hold its last value in SEARCH until a new channel is loaded.

Reset
REQ-033 With rst_n=0 at a clk edge: gate counter, accumulators, edge_cnt, cnt_valid, sel, sel_valid, sel_change, sel_sig SHALL be 0; silence counters SHALL be LOS_CYCLES (los all 1s); FSM SHALL be SEARCH; synchronisers cleared.
REQ-034 Reset asserted mid-window SHALL discard the partial window without a cnt_valid pulse.
REQ-035 sig_o is unaffected by reset.

Verification (NCH=4, GATE_CYCLES=100, LOS_CYCLES=16, HOLDOFF_CYCLES=8)
REQ-036 Reset release, inputs static -> los=4'b1111, sel_valid=0, first cnt_valid at cycle 100 with all edge_cnt=0.
REQ-037 Channel 2 toggling period 10 clk -> edge_cnt[2]=10 each window, los[2]=0 within 4 cycles of first edge.
REQ-038 Ch2 healthy only -> sel=2, sel_change pulse exactly 8 cycles after HOLDOFF entry; then ch0 starts -> sel stays 2.
REQ-039 Stop ch2 while locked, ch0 running -> los[2] rises 16 cycles after last edge, sel_valid falls, sel=0, sel_valid re-rises 8 cycles later.
REQ-040 Ch1 stops during HOLDOFF -> return to SEARCH, no sel_change pulse.
REQ-041 rst_n low at gate cycle 50 for 1 cycle -> no cnt_valid until 100 cycles after release.

Source files
------------

// File: rtl/diff_clk_monitor.sv
// diff_clk_monitor
//   Watches NCH differential clock inputs. Each channel is buffered,
//   synchronised, edge-detected and counted over a fixed gate window. Each
//   channel also has a loss-of-signal detector. A non-revertive selector picks
//   the lowest-index healthy channel, qualifies it after a hold-off period and
//   forwards its synchronised level.
//
// Ports
//   clk        system clock, rising-edge, single domain
//   rst_n      synchronous active-low reset
//   in_p/in_n  differential pin pairs, one per channel
//   sig_o      buffered single-ended signals (combinational, not reset)
//   edge_cnt   rising-edge counts of the last closed window, ch k at [k*CNT_W +: CNT_W]
//   cnt_valid  one-cycle pulse when edge_cnt updates
//   los        per-channel loss-of-signal flags
//   sel        index of the selected channel
//   sel_valid  selected channel is qualified
//   sel_change one-cycle pulse when sel_valid rises
//   sel_sig    registered synchronised level of the selected channel (0 when not valid)

module diff_clk_monitor #(
   parameter int unsigned NCH            = 4,
   parameter int unsigned CNT_W          = 24,
   parameter int unsigned GATE_CYCLES    = 1000000,
   parameter int unsigned LOS_CYCLES     = 1024,
   parameter int unsigned HOLDOFF_CYCLES = 256,
   parameter              DIFF_TERM      = "FALSE"
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       in_p,
   input  logic [NCH-1:0]       in_n,
   output logic [NCH-1:0]       sig_o,
   output logic [NCH*CNT_W-1:0] edge_cnt,
   output logic                 cnt_valid,
   output logic [NCH-1:0]       los,
   output logic [2:0]           sel,
   output logic                 sel_valid,
   output logic                 sel_change,
   output logic                 sel_sig
);

   localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
   localparam int unsigned LOS_W  = $clog2(LOS_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [LOS_W-1:0]  LOS_MAX   = LOS_W'(LOS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   // Elaboration-time parameter sanity checks
   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("diff_clk_monitor: NCH must be 1..8");
   end
   if (GATE_CYCLES < 2) begin : g_bad_gate
      $error("diff_clk_monitor: GATE_CYCLES must be >= 2");
   end
   if (LOS_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_los
      $error("diff_clk_monitor: LOS_CYCLES and HOLDOFF_CYCLES must be >= 1");
   end
   if (DIFF_TERM != "TRUE" && DIFF_TERM != "FALSE") begin : g_bad_term
      $error("diff_clk_monitor: DIFF_TERM must be \"TRUE\" or \"FALSE\"");
   end

   // ------------------------------------------------------------------
   // Differential input buffers
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NCH; k++) begin : g_ibuf
`ifdef DIFF_CLK_MONITOR_XILINX
      IBUFDS #(
         .DIFF_TERM   (DIFF_TERM),
         .IBUF_LOW_PWR("TRUE")
      ) u_ibufds (
         .O (sig_o[k]),
         .I (in_p[k]),
         .IB(in_n[k])
      );
`else
      // Behavioural stand-in for the vendor buffer: high when P is above N
      assign sig_o[k] = in_p[k] & ~in_n[k];
`endif
   end

   // ------------------------------------------------------------------
   // Synchroniser (2 flops) plus edge register
   // ------------------------------------------------------------------
   logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
   logic [NCH-1:0] pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= sig_o;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign pulse = sync2_q & ~sync3_q;

   // ------------------------------------------------------------------
   // Gate window and edge accumulators
   // ------------------------------------------------------------------
   logic [GATE_W-1:0]      gate_q, gate_d;
   logic                   gate_last;
   logic [CNT_W-1:0]       acc_q [NCH];
   logic [CNT_W-1:0]       acc_d [NCH];
   logic [NCH*CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic                   cnt_valid_q;

   assign gate_last = (gate_q == GATE_LAST);

   always_comb begin
      gate_d     = gate_last ? '0 : gate_q + GATE_W'(1);
      edge_cnt_d = edge_cnt_q;
      for (int k = 0; k < int'(NCH); k++) begin
         // Saturating increment; a pulse on the terminal cycle lands in the closing window
         logic [CNT_W-1:0] inc;
         inc = (pulse[k] && acc_q[k] != CNT_MAX) ? acc_q[k] + CNT_W'(1) : acc_q[k];
         if (gate_last) begin
            edge_cnt_d[k*CNT_W +: CNT_W] = inc;
            acc_d[k]                     = '0;
         end else begin
            acc_d[k] = inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gate_q      <= '0;
         edge_cnt_q  <= '0;
         cnt_valid_q <= 1'b0;
         for (int k = 0; k < int'(NCH); k++) acc_q[k] <= '0;
      end else begin
         gate_q      <= gate_d;
         edge_cnt_q  <= edge_cnt_d;
         cnt_valid_q <= gate_last;
         for (int k = 0; k < int'(NCH); k++) acc_q[k] <= acc_d[k];
      end
   end

   assign edge_cnt  = edge_cnt_q;
   assign cnt_valid = cnt_valid_q;

   // ------------------------------------------------------------------
   // Loss-of-signal: silence counters saturating at LOS_CYCLES
   // ------------------------------------------------------------------
   logic [LOS_W-1:0] sil_q [NCH];
   logic [LOS_W-1:0] sil_d [NCH];

   always_comb begin
      for (int k = 0; k < int'(NCH); k++) begin
         if (pulse[k])                sil_d[k] = '0;
         else if (sil_q[k] == LOS_MAX) sil_d[k] = sil_q[k];
         else                          sil_d[k] = sil_q[k] + LOS_W'(1);
      end
   end

   // Reset to LOS_MAX so every channel starts out declared lost
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NCH); k++) sil_q[k] <= LOS_MAX;
      end else begin
         for (int k = 0; k < int'(NCH); k++) sil_q[k] <= sil_d[k];
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_los
      assign los[k] = (sil_q[k] == LOS_MAX);
   end

   // ------------------------------------------------------------------
   // Selection FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      StSearch,
      StHoldoff,
      StLocked
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              sel_valid_q, sel_valid_d;
   logic              sel_change_q, sel_change_d;
   logic              sel_sig_q, sel_sig_d;
   logic [7:0]        los_pad, lvl_pad;
   logic [2:0]        cand;
   logic              found;

   always_comb begin
      // Unused upper channels read as lost/low so a 3-bit index is always safe
      los_pad            = '1;
      los_pad[NCH-1:0]   = los;
      lvl_pad            = '0;
      lvl_pad[NCH-1:0]   = sync2_q;

      // Lowest-index healthy channel
      cand  = '0;
      found = 1'b0;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         if (!los[k]) begin
            cand  = 3'(k);
            found = 1'b1;
         end
      end

      state_d = state_q;
      sel_d   = sel_q;
      hold_d  = hold_q;

      unique case (state_q)
         StSearch: begin
            if (found) begin
               sel_d   = cand;
               hold_d  = '0;
               state_d = StHoldoff;
            end
         end
         StHoldoff: begin
            if (los_pad[sel_q]) begin
               state_d = StSearch;
            end else if (hold_q == HOLD_LAST) begin
               state_d = StLocked;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         StLocked: begin
            // Non-revertive: only loss of the current channel moves us
            if (los_pad[sel_q]) state_d = StSearch;
         end
         default: state_d = StSearch;
      endcase

      sel_valid_d  = (state_d == StLocked);
      sel_change_d = sel_valid_d & ~sel_valid_q;
      sel_sig_d    = sel_valid_d & lvl_pad[sel_d];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StSearch;
         sel_q        <= '0;
         hold_q       <= '0;
         sel_valid_q  <= 1'b0;
         sel_change_q <= 1'b0;
         sel_sig_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         hold_q       <= hold_d;
         sel_valid_q  <= sel_valid_d;
         sel_change_q <= sel_change_d;
         sel_sig_q    <= sel_sig_d;
      end
   end

   assign sel        = sel_q;
   assign sel_valid  = sel_valid_q;
   assign sel_change = sel_change_q;
   assign sel_sig    = sel_sig_q;

endmodule
